// File: rtl/idst7_pkg.sv
// idst7_pkg: shared definitions for the 4-point inverse DST-VII pipeline.
//   - K29/K55/K74/K84 : DST-VII 4x4 kernel magnitudes
//   - DEF_IN_W/DEF_OUT_W : default coefficient / residual widths
//   - ACC_W : accumulator width for the default input width
//   - coef_t/res_t/acc_t : signed datatypes for the default configuration
//   - sat_s64() : clip a signed value into a w-bit two's complement range
package idst7_pkg;

  localparam int K29 = 29;
  localparam int K55 = 55;
  localparam int K74 = 74;
  localparam int K84 = 84;

  localparam int DEF_IN_W  = 16;
  localparam int DEF_OUT_W = 16;

  // Worst-case |sum| is 242 * 2^(IN_W-1); IN_W+10 bits covers it with margin.
  localparam int ACC_W = DEF_IN_W + 10;

  typedef logic signed [DEF_IN_W-1:0]  coef_t;
  typedef logic signed [DEF_OUT_W-1:0] res_t;
  typedef logic signed [ACC_W-1:0]     acc_t;

  // Saturate v into [-2^(w-1), 2^(w-1)-1].
  function automatic logic signed [63:0] sat_s64(input logic signed [63:0] v,
                                                 input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi)
      return hi;
    else if (v < lo)
      return lo;
    else
      return v;
  endfunction

endpackage

// File: rtl/idst7_4_sau.sv
// idst7_4_sau: shift-add multiple generator for one coefficient.
//   c   : signed coefficient (IN_W bits)
//   x29 : 29*c  x55 : 55*c  x74 : 74*c  x84 : 84*c  (IN_W+7 bits, signed)
// Purely combinational; no multipliers are inferred.
module idst7_4_sau #(
  parameter  int IN_W = 16,
  localparam int P_W  = IN_W + 7
) (
  input  logic signed [IN_W-1:0] c,
  output logic signed [P_W-1:0]  x29,
  output logic signed [P_W-1:0]  x55,
  output logic signed [P_W-1:0]  x74,
  output logic signed [P_W-1:0]  x84
);

  logic signed [P_W-1:0] ce;

  assign ce = {{7{c[IN_W-1]}}, c};

  // 29 = 32 - 2 - 1, 55 = 64 - 8 - 1, 74 = 64 + 8 + 2, 84 = 64 + 16 + 4
  assign x29 = (ce <<< 5) - (ce <<< 1) - ce;
  assign x55 = (ce <<< 6) - (ce <<< 3) - ce;
  assign x74 = (ce <<< 6) + (ce <<< 3) + (ce <<< 1);
  assign x84 = (ce <<< 6) + (ce <<< 4) + (ce <<< 2);

endmodule

// File: rtl/idst7_4_pipe.sv
// idst7_4_pipe: 4-point inverse DST-VII, two pipeline stages.
//   clk, rst           : clock, synchronous active-high reset
//   in_valid/in_ready  : input handshake for coef[3:0] (c0 = coef[0])
//   out_valid/out_ready: output handshake for res[3:0] (r0 = res[0])
// S1 registers the 16 kernel multiples; S2 sums, rounds, shifts and clips.
module idst7_4_pipe
  import idst7_pkg::*;
#(
  parameter int SHIFT = 7,
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0][IN_W-1:0]  coef,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3:0][OUT_W-1:0] res
);

  localparam int P_W = IN_W + 7;
  localparam int A_W = IN_W + 10;
  localparam int RND_I = (SHIFT > 0) ? (1 << ((SHIFT > 0) ? (SHIFT - 1) : 0)) : 0;
  localparam logic signed [A_W-1:0] RND = A_W'(RND_I);

  logic signed [P_W-1:0] p29 [4];
  logic signed [P_W-1:0] p55 [4];
  logic signed [P_W-1:0] p74 [4];
  logic signed [P_W-1:0] p84 [4];

  logic signed [P_W-1:0] m29_reg [4];
  logic signed [P_W-1:0] m55_reg [4];
  logic signed [P_W-1:0] m74_reg [4];
  logic signed [P_W-1:0] m84_reg [4];

  logic signed [A_W-1:0] e29 [4];
  logic signed [A_W-1:0] e55 [4];
  logic signed [A_W-1:0] e74 [4];
  logic signed [A_W-1:0] e84 [4];

  logic signed [A_W-1:0]   sum [4];
  logic signed [A_W-1:0]   sh_val [4];
  logic signed [63:0]      wide [4];
  logic [OUT_W-1:0]        res_next [4];
  logic [OUT_W-1:0]        res_reg [4];

  logic s1_valid_reg;
  logic out_valid_reg;
  logic en;

  // S2 may advance whenever its current content is gone or leaving now.
  assign en        = !out_valid_reg || out_ready;
  assign in_ready  = en || !s1_valid_reg;
  assign out_valid = out_valid_reg;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    idst7_4_sau #(.IN_W(IN_W)) u_sau (
      .c   (coef[gi]),
      .x29 (p29[gi]),
      .x55 (p55[gi]),
      .x74 (p74[gi]),
      .x84 (p84[gi])
    );

    assign e29[gi] = A_W'(m29_reg[gi]);
    assign e55[gi] = A_W'(m55_reg[gi]);
    assign e74[gi] = A_W'(m74_reg[gi]);
    assign e84[gi] = A_W'(m84_reg[gi]);

    // Arithmetic shift floors; clipping happens after the shift.
    assign sh_val[gi]   = (sum[gi] + RND) >>> SHIFT;
    assign wide[gi]     = sat_s64(64'(sh_val[gi]), OUT_W);
    assign res_next[gi] = wide[gi][OUT_W-1:0];
    assign res[gi]      = res_reg[gi];
  end

  // Transposed kernel: column j of T gives residual j.
  always_comb begin
    sum[0] = e29[0] + e74[1] + e84[2] + e55[3];
    sum[1] = e55[0] + e74[1] - e29[2] - e84[3];
    sum[2] = e74[0] - e74[2] + e74[3];
    sum[3] = e84[0] - e74[1] + e55[2] - e29[3];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        m29_reg[i] <= '0;
        m55_reg[i] <= '0;
        m74_reg[i] <= '0;
        m84_reg[i] <= '0;
        res_reg[i] <= '0;
      end
    end else begin
      // S1 loads on input handshake; otherwise it empties when S2 takes it.
      if (in_valid && in_ready) begin
        s1_valid_reg <= 1'b1;
        for (int i = 0; i < 4; i++) begin
          m29_reg[i] <= p29[i];
          m55_reg[i] <= p55[i];
          m74_reg[i] <= p74[i];
          m84_reg[i] <= p84[i];
        end
      end else if (en) begin
        s1_valid_reg <= 1'b0;
      end

      // res only changes when a valid vector moves in, so it stays put
      // while stalled and after the last output.
      if (en) begin
        out_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          for (int i = 0; i < 4; i++)
            res_reg[i] <= res_next[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_idst7_4_pipe.sv
// tb_idst7_4_pipe: directed and random checks of idst7_4_pipe at SHIFT 7, 0 and 10.
// Three instances share one stimulus; a scoreboard model checks every output.
module tb_idst7_4_pipe;

  typedef logic [3:0][15:0] vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  vec_t coef = '0;

  logic in_ready7, in_ready0, in_ready10;
  logic out_valid7, out_valid0, out_valid10;
  vec_t res7, res0, res10;

  int checks = 0;
  int errors = 0;
  int n_out = 0;

  vec_t sb_q[$];
  logic hold_pend = 1'b0;
  vec_t held = '0;

  always #5 clk = ~clk;

  idst7_4_pipe #(.SHIFT(7)) dut7 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready7), .coef(coef),
    .out_valid(out_valid7), .out_ready(out_ready), .res(res7));
  idst7_4_pipe #(.SHIFT(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .coef(coef),
    .out_valid(out_valid0), .out_ready(out_ready), .res(res0));
  idst7_4_pipe #(.SHIFT(10)) dut10 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready10), .coef(coef),
    .out_valid(out_valid10), .out_ready(out_ready), .res(res10));

  // Forward DST-VII matrix; the inverse uses its transpose: r_j = sum_i T[i][j]*c_i.
  localparam int KT [4][4] = '{'{29, 55, 74, 84},
                               '{74, 74, 0, -74},
                               '{84, -29, -74, 55},
                               '{55, -84, 74, -29}};

  function automatic vec_t model(input vec_t c, input int sh);
    vec_t r;
    longint acc;
    longint v;
    for (int j = 0; j < 4; j++) begin
      acc = 0;
      for (int i = 0; i < 4; i++)
        acc += longint'(KT[i][j]) * longint'($signed(c[i]));
      v = acc + ((sh > 0) ? (64'sd1 <<< (sh - 1)) : 64'sd0);
      v = v >>> sh;
      if (v > 32767) v = 32767;
      if (v < -32768) v = -32768;
      r[j] = v[15:0];
    end
    return r;
  endfunction

  function automatic vec_t mk(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h required=%h", nm, act, exp);
    end else begin
      $display("ok   %s value=%h", nm, act);
    end
  endtask

  // Scoreboard / compare process, sampled on the falling edge.
  always @(negedge clk) begin
    vec_t c;
    if (rst) begin
      sb_q.delete();
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        checks++;
        if (out_valid7 !== 1'b1 || res7 !== held) begin
          errors++;
          $display("FAIL hold_stable valid=%b res=%h required=%h", out_valid7, res7, held);
        end
      end
      hold_pend = out_valid7 && !out_ready;
      held = res7;
      if (out_valid7 && out_ready) begin
        n_out++;
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL spurious_output res=%h required=no output", res7);
        end else begin
          c = sb_q.pop_front();
          if (res7 !== model(c, 7) || res0 !== model(c, 0) || res10 !== model(c, 10)) begin
            errors++;
            $display("FAIL sb_out coef=%h got7=%h req7=%h got0=%h req0=%h got10=%h req10=%h",
                     c, res7, model(c, 7), res0, model(c, 0), res10, model(c, 10));
          end else begin
            $display("out  coef=%h res7=%h", c, res7);
          end
        end
      end
      if (in_valid && in_ready7) sb_q.push_back(coef);
    end
  end

  // Single vector, open output: 2-cycle latency, one-cycle out_valid.
  task automatic run_single(input string nm, input vec_t c, input vec_t x7,
                            input vec_t x0, input vec_t x10);
    coef = c;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk({nm, "_in_ready"}, 64'(in_ready7), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_lat1_valid"}, 64'(out_valid7), 64'd0);
    @(negedge clk);
    chk({nm, "_lat2_valid"}, 64'(out_valid7), 64'd1);
    chk({nm, "_res_sh7"}, res7, x7);
    chk({nm, "_res_sh0"}, res0, x0);
    chk({nm, "_res_sh10"}, res10, x10);
    @(negedge clk);
    chk({nm, "_valid_drop"}, 64'(out_valid7), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int k;
    int cyc;
    int acc;
    int base;
    vec_t vecs [4];

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 64'(out_valid7), 64'd0);
    chk("reset_res", res7, 64'd0);
    chk("reset_in_ready", 64'(in_ready7), 64'd1);
    @(posedge clk); #1;

    run_single("dc", mk(64, 0, 0, 0), mk(15, 28, 37, 42),
               mk(1856, 3520, 4736, 5376), mk(2, 3, 5, 5));
    run_single("pos_sat", mk(32767, 32767, 32767, 32767), mk(32767, 4096, 18943, 9216),
               mk(32767, 32767, 32767, 32767), mk(7744, 512, 2368, 1152));
    run_single("neg_sat", mk(-32768, -32768, -32768, -32768), mk(-32768, -4096, -18944, -9216),
               mk(-32768, -32768, -32768, -32768), mk(-7744, -512, -2368, -1152));

    // Back-pressure: 4 back-to-back vectors, out_ready low in cycles 2..4.
    vecs[0] = mk(100, -7, 3000, -12345);
    vecs[1] = mk(-1, 1, -1, 1);
    vecs[2] = mk(20000, -20000, 5, 0);
    vecs[3] = mk(-300, 777, -8192, 4095);
    base = n_out;
    k = 0;
    cyc = 0;
    while (k < 4 && cyc < 40) begin
      coef = vecs[k];
      in_valid = 1'b1;
      out_ready = !(cyc >= 2 && cyc <= 4);
      @(negedge clk);
      chk($sformatf("bp_in_ready_c%0d", cyc), 64'(in_ready7), 64'(!(cyc >= 2 && cyc <= 4)));
      if (in_ready7) k++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("bp_all_out", 64'(n_out - base), 64'd4);
    chk("bp_sb_empty", 64'(sb_q.size()), 64'd0);

    // Reset mid-flight: two vectors held in S1/S2, then flushed.
    out_ready = 1'b0;
    coef = mk(100, -200, 300, -400);
    in_valid = 1'b1;
    @(posedge clk); #1;
    coef = mk(1, 2, 3, 4);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_pre_valid", 64'(out_valid7), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid7), 64'd0);
    chk("rst_res7", res7, 64'd0);
    chk("rst_res0", res0, 64'd0);
    chk("rst_in_ready", 64'(in_ready7), 64'd1);
    out_ready = 1'b1;
    base = n_out;
    repeat (6) @(posedge clk);
    #1;
    chk("rst_no_flushed", 64'(n_out - base), 64'd0);
    run_single("post_rst", mk(64, 0, 0, 0), mk(15, 28, 37, 42),
               mk(1856, 3520, 4736, 5376), mk(2, 3, 5, 5));
    chk("post_rst_count", 64'(n_out - base), 64'd1);

    // Random traffic, checked by the scoreboard.
    acc = 0;
    cyc = 0;
    while (acc < 10000 && cyc < 60000) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) begin
        case ($urandom_range(0, 7))
          0: coef[i] = 16'h7fff;
          1: coef[i] = 16'h8000;
          default: coef[i] = 16'($urandom());
        endcase
      end
      @(negedge clk);
      if (in_valid && in_ready7) acc++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("rand_accepted", 64'(acc), 64'd10000);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rand_sb_empty", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
